// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between PPU renderer and posted CPU accesses
module vram_arbiter #(
    parameter int AW       = 13,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r_req,
    input  logic [AW-1:0] r_addr,
    output logic          r_gnt,
    output logic          r_rvalid,
    output logic [DW-1:0] r_rdata,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_busy,
    output logic          c_drop,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

    logic          busy_q;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_wdata;
    logic [WW-1:0] wait_cnt;
    logic          drop_q;
    logic          crd_q;
    logic          rrv_q;
    logic [DW-1:0] rdata_q;
    logic          cpu_slot;
    logic          ren_slot;

    // Renderer wins unless it has already starved a pending CPU access MAX_WAIT times.
    always_comb begin
        cpu_slot  = busy_q & (!r_req | (wait_cnt == WAIT_LIM));
        ren_slot  = !cpu_slot & r_req;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_slot) begin
            mem_addr  = buf_addr;
            mem_we    = buf_we;
            mem_wdata = buf_wdata;
        end else if (ren_slot) begin
            mem_addr  = r_addr;
        end
    end

    assign r_gnt    = ren_slot;
    assign r_rvalid = rrv_q;
    assign r_rdata  = mem_rdata;
    assign c_busy   = busy_q;
    assign c_drop   = drop_q;
    assign c_rvalid = crd_q;
    // Read data is forwarded in its valid cycle and held from the register afterwards.
    assign c_rdata  = crd_q ? mem_rdata : rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= 1'b0;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            wait_cnt  <= '0;
            drop_q    <= 1'b0;
            crd_q     <= 1'b0;
            rrv_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            drop_q <= c_req & busy_q;
            rrv_q  <= ren_slot;
            crd_q  <= cpu_slot & !buf_we;
            if (crd_q) begin
                rdata_q <= mem_rdata;
            end
            if (cpu_slot) begin
                busy_q   <= 1'b0;
                wait_cnt <= '0;
            end else begin
                if (c_req && !busy_q) begin
                    busy_q    <= 1'b1;
                    buf_we    <= c_we;
                    buf_addr  <= c_addr;
                    buf_wdata <= c_wdata;
                end
                if (ren_slot && busy_q && (wait_cnt != WAIT_LIM)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed bench for vram_arbiter (MAX_WAIT=4 and MAX_WAIT=0 instances)
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r_req;
    logic [12:0] r_addr;
    logic        c_req;
    logic        c_we;
    logic [12:0] c_addr;
    logic [7:0]  c_wdata;

    logic        r_gnt, r_rvalid, c_busy, c_drop, c_rvalid, mem_we;
    logic [7:0]  r_rdata, c_rdata, mem_wdata, mem_rdata;
    logic [12:0] mem_addr;

    logic        r_gnt0, r_rvalid0, c_busy0, c_drop0, c_rvalid0, mem_we0;
    logic [7:0]  r_rdata0, c_rdata0, mem_wdata0, mem_rdata0;
    logic [12:0] mem_addr0;

    logic [7:0]  mem  [0:8191];
    logic [7:0]  mem0 [0:8191];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.AW(13), .DW(8), .MAX_WAIT(4)) u_dut (
        .clk(clk), .reset(reset),
        .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_rvalid(r_rvalid), .r_rdata(r_rdata),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_busy(c_busy), .c_drop(c_drop), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    vram_arbiter #(.AW(13), .DW(8), .MAX_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt0), .r_rvalid(r_rvalid0), .r_rdata(r_rdata0),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_busy(c_busy0), .c_drop(c_drop0), .c_rvalid(c_rvalid0), .c_rdata(c_rdata0),
        .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]  = pat(13'(i));
            mem0[i] = pat(13'(i));
        end
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (mem_we0) mem0[mem_addr0] <= mem_wdata0;
        mem_rdata0 <= mem0[mem_addr0];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r_req = 1'b0; r_addr = '0; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        vectors++; if (c_busy !== 1'b0) begin miscompares++; $display("FAIL reset_c_busy: got %b want 0", c_busy); end
        vectors++; if (c_drop !== 1'b0) begin miscompares++; $display("FAIL reset_c_drop: got %b want 0", c_drop); end
        vectors++; if (c_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_c_rvalid: got %b want 0", c_rvalid); end
        vectors++; if (r_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_r_rvalid: got %b want 0", r_rvalid); end
        vectors++; if (c_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_c_rdata: got %h want 00", c_rdata); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 13'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_cpu_write();
        c_req = 1'b1; c_we = 1'b1; c_addr = 13'h0123; c_wdata = 8'hA5;
        #1;
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL wr_n_mem_we: got %b want 0", mem_we); end
        next_cycle();
        idle_inputs();
        #1;
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
        vectors++; if (mem_addr !== 13'h0123) begin miscompares++; $display("FAIL wr_mem_addr: got %h want 0123", mem_addr); end
        vectors++; if (mem_wdata !== 8'hA5) begin miscompares++; $display("FAIL wr_mem_wdata: got %h want a5", mem_wdata); end
        vectors++; if (c_busy !== 1'b1) begin miscompares++; $display("FAIL wr_c_busy: got %b want 1", c_busy); end
        vectors++; if (r_gnt !== 1'b0) begin miscompares++; $display("FAIL wr_r_gnt: got %b want 0", r_gnt); end
        next_cycle();
        #1;
        vectors++; if (c_busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy_clear: got %b want 0", c_busy); end
        vectors++; if (c_rvalid !== 1'b0) begin miscompares++; $display("FAIL wr_no_rvalid: got %b want 0", c_rvalid); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL wr_idle_we: got %b want 0", mem_we); end
        next_cycle();
    endtask

    task automatic test_cpu_read();
        c_req = 1'b1; c_we = 1'b0; c_addr = 13'h0123; c_wdata = 8'hFF;
        next_cycle();
        idle_inputs();
        #1;
        vectors++; if (mem_addr !== 13'h0123) begin miscompares++; $display("FAIL rd_mem_addr: got %h want 0123", mem_addr); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rd_mem_we: got %b want 0", mem_we); end
        vectors++; if (c_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_early_rvalid: got %b want 0", c_rvalid); end
        next_cycle();
        #1;
        vectors++; if (c_rvalid !== 1'b1) begin miscompares++; $display("FAIL rd_rvalid: got %b want 1", c_rvalid); end
        vectors++; if (c_rdata !== 8'hA5) begin miscompares++; $display("FAIL rd_rdata: got %h want a5", c_rdata); end
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            #1;
            vectors++; if (c_rdata !== 8'hA5) begin miscompares++; $display("FAIL rd_hold%0d: got %h want a5", k, c_rdata); end
            vectors++; if (c_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_pulse%0d: got %b want 0", k, c_rvalid); end
        end
    endtask

    task automatic test_max_wait();
        logic        exp_gnt, prev_gnt;
        logic [12:0] exp_addr, prev_addr;
        c_req = 1'b1; c_we = 1'b0; c_addr = 13'h0456;
        next_cycle();
        c_req = 1'b0;
        prev_gnt = 1'b0; prev_addr = '0;
        for (int k = 0; k < 9; k++) begin
            r_req  = 1'b1;
            r_addr = 13'h1000 + 13'((k <= 4) ? k : k - 1);
            exp_gnt  = (k != 4);
            exp_addr = (k == 4) ? 13'h0456 : r_addr;
            #1;
            vectors++; if (r_gnt !== exp_gnt) begin miscompares++; $display("FAIL mw_gnt%0d: got %b want %b", k, r_gnt, exp_gnt); end
            vectors++; if (mem_addr !== exp_addr) begin miscompares++; $display("FAIL mw_addr%0d: got %h want %h", k, mem_addr, exp_addr); end
            vectors++; if (r_rvalid !== prev_gnt) begin miscompares++; $display("FAIL mw_rvalid%0d: got %b want %b", k, r_rvalid, prev_gnt); end
            if (prev_gnt) begin
                vectors++; if (r_rdata !== pat(prev_addr)) begin miscompares++; $display("FAIL mw_rdata%0d: got %h want %h", k, r_rdata, pat(prev_addr)); end
            end
            vectors++; if (c_rvalid !== (k == 5)) begin miscompares++; $display("FAIL mw_c_rvalid%0d: got %b want %b", k, c_rvalid, (k == 5)); end
            if (k == 5) begin
                vectors++; if (c_rdata !== pat(13'h0456)) begin miscompares++; $display("FAIL mw_c_rdata: got %h want %h", c_rdata, pat(13'h0456)); end
            end
            prev_gnt = exp_gnt; prev_addr = exp_addr;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_strict_priority();
        c_req = 1'b1; c_we = 1'b1; c_addr = 13'h0200; c_wdata = 8'h77;
        next_cycle();
        c_req = 1'b0; r_req = 1'b1; r_addr = 13'h1100;
        #1;
        vectors++; if (r_gnt0 !== 1'b0) begin miscompares++; $display("FAIL sp_gnt_first: got %b want 0", r_gnt0); end
        vectors++; if (mem_we0 !== 1'b1) begin miscompares++; $display("FAIL sp_we_first: got %b want 1", mem_we0); end
        vectors++; if (mem_addr0 !== 13'h0200) begin miscompares++; $display("FAIL sp_addr_first: got %h want 0200", mem_addr0); end
        next_cycle();
        #1;
        vectors++; if (r_gnt0 !== 1'b1) begin miscompares++; $display("FAIL sp_gnt_next: got %b want 1", r_gnt0); end
        vectors++; if (mem_addr0 !== 13'h1100) begin miscompares++; $display("FAIL sp_addr_next: got %h want 1100", mem_addr0); end
        vectors++; if (mem_we0 !== 1'b0) begin miscompares++; $display("FAIL sp_we_next: got %b want 0", mem_we0); end
        next_cycle();
        idle_inputs();
        for (int k = 0; k < 3; k++) next_cycle();
    endtask

    task automatic test_drop();
        c_req = 1'b1; c_we = 1'b1; c_addr = 13'h0300; c_wdata = 8'h11;
        next_cycle();
        c_addr = 13'h0311; c_wdata = 8'h22;
        #1;
        vectors++; if (mem_addr !== 13'h0300) begin miscompares++; $display("FAIL dr_addr: got %h want 0300", mem_addr); end
        vectors++; if (mem_wdata !== 8'h11) begin miscompares++; $display("FAIL dr_wdata: got %h want 11", mem_wdata); end
        vectors++; if (c_drop !== 1'b0) begin miscompares++; $display("FAIL dr_early: got %b want 0", c_drop); end
        next_cycle();
        idle_inputs();
        #1;
        vectors++; if (c_drop !== 1'b1) begin miscompares++; $display("FAIL dr_pulse: got %b want 1", c_drop); end
        vectors++; if (c_busy !== 1'b0) begin miscompares++; $display("FAIL dr_busy: got %b want 0", c_busy); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL dr_we: got %b want 0", mem_we); end
        next_cycle();
        #1;
        vectors++; if (c_drop !== 1'b0) begin miscompares++; $display("FAIL dr_one_cycle: got %b want 0", c_drop); end
        vectors++; if (mem[13'h0311] !== pat(13'h0311)) begin miscompares++; $display("FAIL dr_mem_untouched: got %h want %h", mem[13'h0311], pat(13'h0311)); end
        vectors++; if (mem[13'h0300] !== 8'h11) begin miscompares++; $display("FAIL dr_mem_written: got %h want 11", mem[13'h0300]); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        c_req = 1'b1; c_we = 1'b0; c_addr = 13'h0123; r_req = 1'b1; r_addr = 13'h1200;
        next_cycle();
        c_req = 1'b0;
        #1;
        vectors++; if (c_busy !== 1'b1) begin miscompares++; $display("FAIL rm_busy_pre: got %b want 1", c_busy); end
        vectors++; if (r_rvalid !== 1'b1) begin miscompares++; $display("FAIL rm_rvalid_pre: got %b want 1", r_rvalid); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (c_busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %b want 0", c_busy); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rm_we: got %b want 0", mem_we); end
        vectors++; if (r_rvalid !== 1'b0) begin miscompares++; $display("FAIL rm_rvalid: got %b want 0", r_rvalid); end
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            #1;
            vectors++; if (c_rvalid !== 1'b0) begin miscompares++; $display("FAIL rm_lost_c%0d: got %b want 0", k, c_rvalid); end
            vectors++; if (r_rvalid !== 1'b0) begin miscompares++; $display("FAIL rm_lost_r%0d: got %b want 0", k, r_rvalid); end
            vectors++; if (c_rdata !== 8'h00) begin miscompares++; $display("FAIL rm_rdata%0d: got %h want 00", k, c_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_max_wait();
        test_strict_priority();
        test_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
